axis_fir_equalizer: RTL and testbench



---
 rtl/axis_fir_eq_pkg.sv | 27 ++
 rtl/fir_eq_mac.sv | 57 +++++
 rtl/axis_fir_equalizer.sv | 102 ++++++++++
 tb/tb_axis_fir_equalizer.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_fir_eq_pkg.sv
// Shared widths, cfg_data field offsets and sample/product/sum types for the FIR equalizer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axis_fir_eq_pkg;

  localparam int DATA_W = 16;
  localparam int PROD_W = 32;
  localparam int SUM_W  = 34;
  localparam int CFG_W  = 80;

  // cfg_data layout, shared with the stream IIR section
  localparam int B0_LSB  = 0;
  localparam int B1_LSB  = 16;
  localparam int B2_LSB  = 32;
  localparam int MIN_LSB = 48;
  localparam int MAX_LSB = 64;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [SUM_W-1:0]  sum_t;

  // Pull one signed 16-bit field out of the config word.
  function automatic sample_t cfg_field(input logic [CFG_W-1:0] cfg, input int lsb);
    return sample_t'(cfg[lsb +: DATA_W]);
  endfunction

endpackage

// File: rtl/fir_eq_mac.sv
// Multiply-accumulate core: three signed taps multiplied, then summed into 34 bits.
// Latency: 2 cycles (product register, then sum register).
// Backpressure: every register holds while en_i is low; valid travels alongside the data.
module fir_eq_mac
  import axis_fir_eq_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    en_i,
  input  logic    v_i,
  input  sample_t x0_i,
  input  sample_t x1_i,
  input  sample_t x2_i,
  input  sample_t b0_i,
  input  sample_t b1_i,
  input  sample_t b2_i,
  output logic    v_o,
  output sum_t    sum_o
);

  prod_t p0_d, p1_d, p2_d;
  prod_t p0_q, p1_q, p2_q;
  logic  v2_q;
  sum_t  s_d, s_q;
  logic  v3_q;

  // Full-precision products and their sign-extended sum; operands widened first so no bits are lost.
  always_comb begin
    p0_d = prod_t'(x0_i) * prod_t'(b0_i);
    p1_d = prod_t'(x1_i) * prod_t'(b1_i);
    p2_d = prod_t'(x2_i) * prod_t'(b2_i);
    s_d  = sum_t'(p0_q) + sum_t'(p1_q) + sum_t'(p2_q);
  end

  // Product stage and sum stage advance together on the shared enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p0_q <= '0;
      p1_q <= '0;
      p2_q <= '0;
      v2_q <= 1'b0;
      s_q  <= '0;
      v3_q <= 1'b0;
    end else if (en_i) begin
      p0_q <= p0_d;
      p1_q <= p1_d;
      p2_q <= p2_d;
      v2_q <= v_i;
      s_q  <= s_d;
      v3_q <= v2_q;
    end
  end

  assign v_o   = v3_q;
  assign sum_o = s_q;

endmodule

// File: rtl/axis_fir_equalizer.sv
// 3-tap zero-only equalizer y = sat((b0*x + b1*x[n-1] + b2*x[n-2]) >>> SHIFT); AXI-Stream in/out.
// Latency: 4 cycles from input acceptance to m_axis_tvalid; 1 sample/cycle throughput.
// Backpressure: global stall, s_axis_tready = ~m_axis_tvalid | m_axis_tready. AXIS_FIR_EQ_ROUND_EN selects round-half-up.
module axis_fir_equalizer
  import axis_fir_eq_pkg::*;
#(
  parameter int SHIFT      = 14,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [CFG_W-1:0]      cfg_data,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
);

`ifdef AXIS_FIR_EQ_ROUND_EN
  localparam sum_t RND = sum_t'(64'sd1 <<< (SHIFT - 1));
`endif

  logic    en;
  logic    v1_q;
  sample_t x0_q, x1_q, x2_q;
  logic    v3;
  sum_t    sum3;
  sum_t    r;
  sum_t    min_ext, max_ext;
  sample_t tdata_d, tdata_q;
  logic    tvalid_q;

  // Whole pipeline moves only when the output register is empty or being drained.
  assign en            = ~tvalid_q | m_axis_tready;
  assign s_axis_tready = en;

  // Sample register / delay line: shifts only on an accepted sample, so bubbles leave history intact.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      v1_q <= 1'b0;
      x0_q <= '0;
      x1_q <= '0;
      x2_q <= '0;
    end else if (en) begin
      v1_q <= s_axis_tvalid;
      if (s_axis_tvalid) begin
        x0_q <= sample_t'(s_axis_tdata);
        x1_q <= x0_q;
        x2_q <= x1_q;
      end
    end
  end

  fir_eq_mac u_mac (
    .clk   (aclk),
    .rst   (areset),
    .en_i  (en),
    .v_i   (v1_q),
    .x0_i  (x0_q),
    .x1_i  (x1_q),
    .x2_i  (x2_q),
    .b0_i  (cfg_field(cfg_data, B0_LSB)),
    .b1_i  (cfg_field(cfg_data, B1_LSB)),
    .b2_i  (cfg_field(cfg_data, B2_LSB)),
    .v_o   (v3),
    .sum_o (sum3)
  );

  // Scale the sum, then clamp on full-width values; the min test wins when min > max.
  always_comb begin
    min_ext = sum_t'(cfg_field(cfg_data, MIN_LSB));
    max_ext = sum_t'(cfg_field(cfg_data, MAX_LSB));
`ifdef AXIS_FIR_EQ_ROUND_EN
    r       = (sum3 + RND) >>> SHIFT;
`else
    r       = sum3 >>> SHIFT;
`endif
    tdata_d = r[DATA_W-1:0];
    if (r < min_ext) begin
      tdata_d = min_ext[DATA_W-1:0];
    end else if (r > max_ext) begin
      tdata_d = max_ext[DATA_W-1:0];
    end
  end

  // Output register; holds its beat while the consumer stalls.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
    end else if (en) begin
      tvalid_q <= v3;
      tdata_q  <= tdata_d;
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;

endmodule

// File: tb/tb_axis_fir_equalizer.sv
module tb_axis_fir_equalizer;

  localparam int SHIFT = 14;

  logic        aclk = 1'b0;
  logic        areset;
  logic [79:0] cfg_data;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;

  always #5 aclk = ~aclk;

  axis_fir_equalizer #(.SHIFT(SHIFT), .DATA_WIDTH(16)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .cfg_data      (cfg_data),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  int n_pass   = 0;
  int n_checks = 0;

  // reference model state: coefficients, accepted-sample history, scoreboard queues
  int mb0, mb1, mb2, mmin, mmax;
  int h1, h2, xi;
  int exp_q[$];
  int got_q[$];
  int n_acc, n_del;

  function automatic int model_y(int x, int x1, int x2);
    longint acc;
    longint r;
    acc = longint'(mb0) * x + longint'(mb1) * x1 + longint'(mb2) * x2;
`ifdef AXIS_FIR_EQ_ROUND_EN
    acc = acc + (longint'(1) << (SHIFT - 1));
`endif
    r = acc >>> SHIFT;
    if (r < mmin) return mmin;
    if (r > mmax) return mmax;
    return int'(r);
  endfunction

  // Observe transfers mid-cycle: values are stable until the next rising edge commits them.
  always @(negedge aclk) begin
    if (areset) begin
      h1 = 0; h2 = 0; n_acc = 0; n_del = 0;
      exp_q.delete();
      got_q.delete();
    end else begin
      if (s_axis_tvalid && s_axis_tready) begin
        xi = int'($signed(s_axis_tdata));
        exp_q.push_back(model_y(xi, h1, h2));
        h2 = h1;
        h1 = xi;
        n_acc++;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        got_q.push_back(int'($signed(m_axis_tdata)));
        n_del++;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d checks=%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic set_cfg(input int b0, input int b1, input int b2, input int mn, input int mx);
    mb0 = b0; mb1 = b1; mb2 = b2; mmin = mn; mmax = mx;
    cfg_data = {mx[15:0], mn[15:0], b2[15:0], b1[15:0], b0[15:0]};
  endtask

  task automatic do_reset();
    s_axis_tvalid = 1'b0;
    areset = 1'b1;
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
  endtask

  task automatic send(input int x);
    bit acc;
    acc = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 16'(x);
    for (int t = 0; t < 200; t++) begin
      acc = s_axis_tready;
      @(posedge aclk);
      #1;
      if (acc) break;
    end
    s_axis_tvalid = 1'b0;
    if (!acc) begin
      n_checks++;
      $display("FAIL send_timeout: sample %0d never accepted", x);
    end
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic drain();
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    for (int t = 0; t < 100; t++) begin
      if (n_acc == n_del) break;
      @(posedge aclk);
      #1;
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    m_axis_tready = 1'b1;
    set_cfg(16384, 0, 0, -32768, 32767);
    repeat (2) @(posedge aclk);
    #1;
    n_checks++;
    if (m_axis_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid);
    else n_pass++;
    n_checks++;
    if (m_axis_tdata !== 16'h0000) $display("FAIL reset_tdata: got %h want 0000", m_axis_tdata);
    else n_pass++;
    areset = 1'b0;
    #1;
    n_checks++;
    if (s_axis_tready !== 1'b1) $display("FAIL reset_tready: got %b want 1", s_axis_tready);
    else n_pass++;
  endtask

  task automatic test_passthrough();
    int xs[3];
    int lat;
    xs = '{1000, -2000, 32767};
    do_reset();
    set_cfg(16384, 0, 0, -32768, 32767);
    m_axis_tready = 1'b1;
    lat = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 16'(xs[0]);
    for (int c = 1; c <= 12; c++) begin
      @(posedge aclk);
      #1;
      if (c < 3) s_axis_tdata = 16'(xs[c]);
      else s_axis_tvalid = 1'b0;
      if (m_axis_tvalid && lat == 0) lat = c;
    end
    n_checks++;
    if (lat !== 4) $display("FAIL pass_latency: got %0d cycles want 4", lat);
    else n_pass++;
    drain();
    n_checks++;
    if (got_q.size() !== 3) $display("FAIL pass_count: got %0d want 3", got_q.size());
    else n_pass++;
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== xs[i]) $display("FAIL pass_data[%0d]: got %0d want %0d", i, got_q[i], xs[i]);
      else n_pass++;
    end
  endtask

  task automatic test_impulse();
    int want[4];
    want = '{16384, -8192, 4096, 0};
    do_reset();
    set_cfg(16384, -8192, 4096, -32768, 32767);
    send(16384); send(0); send(0); send(0);
    drain();
    n_checks++;
    if (got_q.size() !== 4) $display("FAIL impulse_count: got %0d want 4", got_q.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== want[i]) $display("FAIL impulse[%0d]: got %0d want %0d", i, got_q[i], want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_saturation();
    do_reset();
    set_cfg(32767, 0, 0, -1000, 1000);
    send(32767); send(-32768);
    drain();
    n_checks++;
    if (got_q.size() !== 2) $display("FAIL sat_count: got %0d want 2", got_q.size());
    else n_pass++;
    if (got_q.size() == 2) begin
      n_checks++;
      if (got_q[0] !== 1000) $display("FAIL sat_high: got %0d want 1000", got_q[0]);
      else n_pass++;
      n_checks++;
      if (got_q[1] !== -1000) $display("FAIL sat_low: got %0d want -1000", got_q[1]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int  nxt;
    int  c;
    int  max_inflight;
    int  stall_bad;
    int  stall_seen;
    bit  acc;
    do_reset();
    set_cfg(16384, 0, 0, -32768, 32767);
    nxt = 1; c = 0; max_inflight = 0; stall_bad = 0; stall_seen = 0;
    while (nxt <= 50 && c < 500) begin
      m_axis_tready = !(c >= 15 && c < 25);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 16'(nxt);
      #1;
      if (m_axis_tvalid && !m_axis_tready) begin
        stall_seen++;
        if (s_axis_tready !== 1'b0) stall_bad++;
      end
      if (n_acc - n_del > max_inflight) max_inflight = n_acc - n_del;
      acc = s_axis_tready;
      @(posedge aclk);
      #1;
      if (acc) nxt++;
      c++;
    end
    drain();
    n_checks++;
    if (stall_seen < 5 || stall_bad != 0)
      $display("FAIL bp_tready: stalled cycles %0d with tready high in %0d, want >=5 and 0", stall_seen, stall_bad);
    else n_pass++;
    n_checks++;
    if (max_inflight > 4) $display("FAIL bp_inflight: got %0d want <=4", max_inflight);
    else n_pass++;
    n_checks++;
    if (got_q.size() !== 50) $display("FAIL bp_count: got %0d want 50", got_q.size());
    else n_pass++;
    for (int i = 0; i < got_q.size() && i < 50; i++) begin
      n_checks++;
      if (got_q[i] !== i + 1) $display("FAIL bp_data[%0d]: got %0d want %0d", i, got_q[i], i + 1);
      else n_pass++;
    end
  endtask

  task automatic test_bubbles();
    do_reset();
    set_cfg(16384, 16384, 0, -32768, 32767);
    m_axis_tready = 1'b1;
    send(100);
    idle(5);
    send(200);
    drain();
    n_checks++;
    if (got_q.size() !== 2) $display("FAIL bubble_count: got %0d want 2", got_q.size());
    else n_pass++;
    if (got_q.size() == 2) begin
      n_checks++;
      if (got_q[0] !== 100) $display("FAIL bubble_first: got %0d want 100", got_q[0]);
      else n_pass++;
      n_checks++;
      if (got_q[1] !== 300) $display("FAIL bubble_second: got %0d want 300", got_q[1]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    set_cfg(16384, 16384, 16384, -32768, 32767);
    m_axis_tready = 1'b1;
    send(7); send(8); send(9); send(10);
    n_checks++;
    if (m_axis_tvalid !== 1'b1) $display("FAIL mid_pre_tvalid: got %b want 1", m_axis_tvalid);
    else n_pass++;
    areset = 1'b1;
    #1;
    n_checks++;
    if (m_axis_tvalid !== 1'b0) $display("FAIL mid_async_tvalid: got %b want 0", m_axis_tvalid);
    else n_pass++;
    @(posedge aclk);
    @(posedge aclk);
    #1 areset = 1'b0;
    send(5);
    drain();
    n_checks++;
    if (got_q.size() !== 1) $display("FAIL mid_count: got %0d want 1", got_q.size());
    else n_pass++;
    if (got_q.size() == 1) begin
      n_checks++;
      if (got_q[0] !== 5) $display("FAIL mid_data: got %0d want 5", got_q[0]);
      else n_pass++;
    end
  endtask

  task automatic test_rounding();
    int want;
`ifdef AXIS_FIR_EQ_ROUND_EN
    want = 1;
`else
    want = 0;
`endif
    do_reset();
    set_cfg(8192, 0, 0, -32768, 32767);
    send(1);
    drain();
    n_checks++;
    if (got_q.size() !== 1 || got_q[0] !== want)
      $display("FAIL rounding: got %0d outputs first %0d want 1 output %0d",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 0, want);
    else n_pass++;
  endtask

  task automatic test_random(input bit inverted_clamp);
    int lo, hi;
    int errs;
    do_reset();
    lo = int'($urandom_range(0, 30000)) - 32768;
    hi = int'($urandom_range(0, 30000));
    if (inverted_clamp) set_cfg(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                                int'($urandom_range(0, 65535)) - 32768, 200, -200);
    else set_cfg(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                 int'($urandom_range(0, 65535)) - 32768, lo, hi);
    for (int c = 0; c < 400; c++) begin
      s_axis_tvalid = ($urandom_range(0, 3) != 0);
      s_axis_tdata  = 16'($urandom_range(0, 65535));
      m_axis_tready = ($urandom_range(0, 2) != 0);
      @(posedge aclk);
      #1;
    end
    drain();
    n_checks++;
    if (got_q.size() !== exp_q.size() || got_q.size() < 50)
      $display("FAIL rand_count: got %0d outputs want %0d (>=50)", got_q.size(), exp_q.size());
    else n_pass++;
    errs = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        if (errs < 5) $display("FAIL rand_data[%0d]: got %0d want %0d", i, got_q[i], exp_q[i]);
        errs++;
      end
    end
    n_checks++;
    if (errs != 0) $display("FAIL rand_data_total: got %0d wrong samples want 0", errs);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_impulse();
    test_saturation();
    test_backpressure();
    test_bubbles();
    test_reset_midstream();
    test_rounding();
    test_random(1'b0);
    test_random(1'b1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
